// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the coordinate type for the VGA pixel interface.
`timescale 1ns/1ps
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    localparam int H_TOTAL  = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL  = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int HS_START = H_VISIBLE_DEF + H_FP_DEF;
    localparam int HS_END   = HS_START + H_SYNC_DEF - 1;
    localparam int VS_START = V_VISIBLE_DEF + V_FP_DEF;
    localparam int VS_END   = VS_START + V_SYNC_DEF - 1;

    // Idle value of the {hs, vs, blank} bundle: syncs deasserted, display disabled.
    localparam logic [2:0] SYNC_IDLE = 3'b110;

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-depth shift register for the sync/blank bundle; DEPTH=0 degenerates to a wire.
`timescale 1ns/1ps
module sync_delay_line #(
    parameter int                 WIDTH     = 3,
    parameter int                 DEPTH     = 2,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        wire unused_ok = &{1'b0, clk, reset_n};
        assign dout = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] pipe [DEPTH];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < DEPTH; i++) pipe[i] <= RESET_VAL;
            end else begin
                pipe[0] <= din;
                for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
            end
        end

        assign dout = pipe[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: DrawX/DrawY, blank, active-low syncs, delayed syncs and frame pulse.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN.
`timescale 1ns/1ps
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE   = H_VISIBLE_DEF,
    parameter int H_FP        = H_FP_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BP        = H_BP_DEF,
    parameter int V_VISIBLE   = V_VISIBLE_DEF,
    parameter int V_FP        = V_FP_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BP        = V_BP_DEF,
    parameter int PIPE_DLY    = 2,
    parameter int FRAME_CNT_W = 8
) (
    input  logic                   vga_clk,
    input  logic                   reset_n,
    output coord_t                 DrawX,
    output coord_t                 DrawY,
    output logic                   blank,
    output logic                   hs,
    output logic                   vs,
    output logic                   hs_d,
    output logic                   vs_d,
    output logic                   blank_d,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam coord_t X_LAST = coord_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t Y_LAST = coord_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t X_VIS  = coord_t'(H_VISIBLE);
    localparam coord_t Y_VIS  = coord_t'(V_VISIBLE);
    localparam coord_t HS_S   = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_E   = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam coord_t VS_S   = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_E   = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

    coord_t x_nxt;
    coord_t y_nxt;

    always_comb begin
        x_nxt = DrawX + coord_t'(1);
        y_nxt = DrawY;
        if (DrawX == X_LAST) begin
            x_nxt = '0;
            y_nxt = (DrawY == Y_LAST) ? coord_t'(0) : DrawY + coord_t'(1);
        end
    end

    // Flags decode the next position so they line up with the counters they describe.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            DrawX       <= x_nxt;
            DrawY       <= y_nxt;
            blank       <= (x_nxt < X_VIS) && (y_nxt < Y_VIS);
            hs          <= !((x_nxt >= HS_S) && (x_nxt <= HS_E));
            vs          <= !((y_nxt >= VS_S) && (y_nxt <= VS_E));
            frame_start <= (x_nxt == '0) && (y_nxt == '0);
        end
    end

    sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DLY),
        .RESET_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .clk     (vga_clk),
        .reset_n (reset_n),
        .din     ({hs, vs, blank}),
        .dout    ({hs_d, vs_d, blank_d})
    );

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n)
            frame_cnt <= '0;
        else if (frame_start)
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
`else
    assign frame_cnt = '0;
`endif

endmodule
